regbank_wr_arbiter: RTL

REGBANK_WR_ARBITER -- requirements
Module: regbank_wr_arbiter

---
 rtl/regbank_pkg.sv | 19 +
 rtl/rr_pick.sv | 35 +++
 rtl/regbank_wr_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared state type, default parameters and index helper for the bank write arbiter
package regbank_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   localparam int DEF_N        = 32;
   localparam int DEF_W        = 32;
   localparam int DEF_R        = 4;
   localparam int DEF_LOCK_MAX = 16;

   // Next requester index after i, wrapping at r.
   function automatic int wrap_inc(input int i, input int r);
      return (i + 1 >= r) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority search: first requester at or after ptr_i, ascending with wrap
module rr_pick #(
   parameter int  R  = 4,
   localparam int IW = $clog2(R)
) (
   input  logic [R-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [R-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);

   always_comb begin
      int            j;
      logic [IW-1:0] jj;
      logic          found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int k = 0; k < R; k++) begin
         j = int'(ptr_i) + k;
         if (j >= R) begin
            j = j - R;
         end
         jj = IW'(j);
         if (!found && req_i[jj]) begin
            found     = 1'b1;
            gnt_o[jj] = 1'b1;
            idx_o     = jj;
         end
      end
   end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// rtl/regbank_wr_arbiter.sv - round-robin write arbiter with ownership lock feeding the register bank
module regbank_wr_arbiter
   import regbank_pkg::*;
#(
   parameter int  N        = DEF_N,
   parameter int  W        = DEF_W,
   parameter int  R        = DEF_R,
   parameter int  LOCK_MAX = DEF_LOCK_MAX,
   localparam int AW       = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [R-1:0]    req,
   input  logic [R-1:0]    req_lock,
   input  logic [R*AW-1:0] req_addr,
   input  logic [R*W-1:0]  req_data,
   output logic [R-1:0]    gnt,
   output logic [AW-1:0]   reg_wr_cod,
   output logic            wr_en,
   output logic [W-1:0]    wr_data,
   output logic            lock_abort
);

   localparam int          IW    = $clog2(R);
   localparam int          CW    = $clog2(LOCK_MAX + 1);
   localparam logic [AW:0] N_LIM = N[AW:0];

   state_e        state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_cod_q, wr_cod_d;
   logic [W-1:0]  wr_data_q, wr_data_d;
   logic          abort_q, abort_d;

   logic [R-1:0]  pick_gnt;
   logic [IW-1:0] pick_idx;
   logic [R-1:0]  gnt_c;
   logic [IW-1:0] xfer_idx;
   logic          xfer;
   logic          xfer_lock;
   logic [AW-1:0] xfer_addr;
   logic [W-1:0]  xfer_data;
   logic          addr_ok;

   logic [AW-1:0] addr_a [R];
   logic [W-1:0]  data_a [R];

   for (genvar g = 0; g < R; g++) begin : g_unpack
      assign addr_a[g] = req_addr[g*AW +: AW];
      assign data_a[g] = req_data[g*W +: W];
   end

   rr_pick #(
      .R (R)
   ) u_rr_pick (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   // Grant is a pure function of req and arbiter state; lock and payload never feed it.
   always_comb begin
      gnt_c    = '0;
      xfer_idx = pick_idx;
      if (state_q == ST_LOCKED) begin
         xfer_idx       = owner_q;
         gnt_c[owner_q] = req[owner_q];
      end else begin
         gnt_c = pick_gnt;
      end
      if (!rst_n) begin
         gnt_c = '0;
      end
   end

   assign xfer      = |(req & gnt_c);
   assign xfer_lock = req_lock[xfer_idx];
   assign xfer_addr = addr_a[xfer_idx];
   assign xfer_data = data_a[xfer_idx];
   assign addr_ok   = ({1'b0, xfer_addr} < N_LIM);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      idle_cnt_d = idle_cnt_q;
      wr_en_d    = 1'b0;
      wr_cod_d   = wr_cod_q;
      wr_data_d  = wr_data_q;
      abort_d    = 1'b0;
      if (xfer) begin
         rr_ptr_d   = IW'(wrap_inc(int'(xfer_idx), R));
         idle_cnt_d = '0;
         if (xfer_lock) begin
            state_d = ST_LOCKED;
            owner_d = xfer_idx;
         end else begin
            state_d = ST_IDLE;
         end
         // Out-of-range addresses are acked but never reach the bank.
         if (addr_ok) begin
            wr_en_d   = 1'b1;
            wr_cod_d  = xfer_addr;
            wr_data_d = xfer_data;
         end
      end else if (state_q == ST_LOCKED) begin
         if (idle_cnt_q == CW'(LOCK_MAX - 1)) begin
            state_d    = ST_IDLE;
            idle_cnt_d = '0;
            abort_d    = 1'b1;
            rr_ptr_d   = IW'(wrap_inc(int'(owner_q), R));
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         idle_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         wr_cod_q   <= '0;
         wr_data_q  <= '0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         idle_cnt_q <= idle_cnt_d;
         wr_en_q    <= wr_en_d;
         wr_cod_q   <= wr_cod_d;
         wr_data_q  <= wr_data_d;
         abort_q    <= abort_d;
      end
   end

   assign gnt        = gnt_c;
   assign reg_wr_cod = wr_cod_q;
   assign wr_en      = wr_en_q;
   assign wr_data    = wr_data_q;
   assign lock_abort = abort_q;

endmodule
